// File: rtl/fb_fetch_if.sv
// Memory read bus and pixel stream between fb_fetch (master) and its surroundings (slave).
interface fb_fetch_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        pixel_empty_n;
  logic [31:0] pixel_word;
  logic        pixel_deq;
  logic        underflow;

  modport master (
    output mem_req_valid, mem_req_addr, pixel_empty_n, pixel_word, underflow,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, pixel_deq
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, pixel_empty_n, pixel_word, underflow,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, pixel_deq
  );
endinterface

// File: rtl/fb_fetch.sv
// Framebuffer fetcher: streams a frame of 32-bit pixel words from memory into a
// credit-limited show-ahead FIFO; a mid-frame restart drains in-flight reads first.
module fb_fetch #(
  parameter int unsigned H_RES = 1024,
  parameter int unsigned V_RES = 768,
  parameter int unsigned DEPTH = 16
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic [31:0] fb_base,
  input  logic        frame_start,
  output logic        busy,
  fb_fetch_if.master  bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [19:0] Words = 20'(H_RES * V_RES / 4);

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [CntW:0]   credit_t;
  typedef logic [PtrW-1:0] ptr_t;

  typedef enum logic [1:0] {StIdle, StFetch, StFlush} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [19:0] req_cnt_q, req_cnt_d;
  cnt_t        outst_q, outst_d;
  cnt_t        count_q, count_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  logic        req_valid_q, req_valid_d;
  logic        underflow_q, underflow_d;
  logic [31:0] fifo_mem [DEPTH];

  logic        hs, rsp_ok, deq_ok, enq, enq_ok, clear;
  logic [31:0] base_aligned;
  credit_t     credit;

  assign base_aligned = fb_base & 32'hFFFF_FFFC;
  assign hs     = req_valid_q & bus.mem_req_ready;
  // Responses with nothing outstanding (e.g. stragglers from before reset) are dropped.
  assign rsp_ok = bus.mem_rsp_valid && (outst_q != '0) && (state_q != StIdle);
  assign deq_ok = bus.pixel_deq && (count_q != '0);

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      req_cnt_q   <= '0;
      outst_q     <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      req_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      req_cnt_q   <= req_cnt_d;
      outst_q     <= outst_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      req_valid_q <= req_valid_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge pix_clk) begin
    if (!rst && enq_ok) begin
      fifo_mem[wr_ptr_q] <= bus.mem_rsp_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = hs ? addr_q + 32'd4 : addr_q;
    req_cnt_d = hs ? req_cnt_q + 20'd1 : req_cnt_q;
    outst_d   = outst_q + cnt_t'(hs) - cnt_t'(rsp_ok);
    clear     = 1'b0;
    enq       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          addr_d    = base_aligned;
          req_cnt_d = '0;
          state_d   = StFetch;
        end
      end
      StFetch: begin
        enq = rsp_ok;
        if (frame_start) begin
          clear  = 1'b1;
          addr_d = base_aligned;
          // Includes a request accepted this very cycle, so its response is flushed too.
          if (outst_d != '0) begin
            state_d = StFlush;
          end else begin
            req_cnt_d = '0;
          end
        end else if (req_cnt_q == Words && outst_q == '0) begin
          state_d = StIdle;
        end
      end
      StFlush: begin
        if (frame_start) begin
          addr_d = base_aligned;
        end
        if (outst_d == '0) begin
          state_d   = StFetch;
          req_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Credit accounting keeps the FIFO from overflowing; the full guard only protects
    // contents against a misbehaving memory.
    enq_ok = enq && !clear && ((count_q != cnt_t'(DEPTH)) || deq_ok);

    if (clear) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + cnt_t'(enq_ok) - cnt_t'(deq_ok);
      wr_ptr_d = wr_ptr_q + ptr_t'(enq_ok);
      rd_ptr_d = rd_ptr_q + ptr_t'(deq_ok);
    end

    credit      = {1'b0, count_d} + {1'b0, outst_d};
    req_valid_d = (state_d == StFetch) && (req_cnt_d < Words) && (credit < credit_t'(DEPTH));
    underflow_d = bus.pixel_deq && (count_q == '0);
  end

  always_comb begin
    busy              = (state_q != StIdle);
    bus.mem_req_valid = req_valid_q;
    bus.mem_req_addr  = addr_q;
    bus.pixel_empty_n = (count_q != '0);
    bus.pixel_word    = (count_q != '0) ? fifo_mem[rd_ptr_q] : '0;
    bus.underflow     = underflow_q;
  end

endmodule

// File: tb/tb_fb_fetch.sv
// Directed bench for fb_fetch: a default-sized instance and a 16x2 instance share one
// in-order memory model; a select signal routes stimulus to one of them at a time.
module tb_fb_fetch;

  logic        pix_clk = 1'b0;
  logic        rst, frame_start, mem_req_ready, mem_rsp_valid, pixel_deq, sel, hold;
  logic [31:0] fb_base, mem_rsp_data;
  logic        busy_a, busy_b;

  logic        cur_valid, cur_empty_n, cur_underflow, cur_busy;
  logic [31:0] cur_addr, cur_word;

  int          n_checks, n_errors, ufl_seen, popped, bad;
  logic        stable, empty_seen;
  logic [31:0] pend[$];
  logic [31:0] req_log[$];

  always #5 pix_clk = ~pix_clk;

  fb_fetch_if ifa ();
  fb_fetch_if ifb ();

  assign ifa.mem_req_ready = mem_req_ready & ~sel;
  assign ifa.mem_rsp_valid = mem_rsp_valid & ~sel;
  assign ifa.mem_rsp_data  = mem_rsp_data;
  assign ifa.pixel_deq     = pixel_deq & ~sel;
  assign ifb.mem_req_ready = mem_req_ready & sel;
  assign ifb.mem_rsp_valid = mem_rsp_valid & sel;
  assign ifb.mem_rsp_data  = mem_rsp_data;
  assign ifb.pixel_deq     = pixel_deq & sel;

  fb_fetch #(.H_RES(1024), .V_RES(768), .DEPTH(16)) u_dut_a (
    .pix_clk     (pix_clk),
    .rst         (rst),
    .fb_base     (fb_base),
    .frame_start (frame_start & ~sel),
    .busy        (busy_a),
    .bus         (ifa)
  );

  fb_fetch #(.H_RES(16), .V_RES(2), .DEPTH(16)) u_dut_b (
    .pix_clk     (pix_clk),
    .rst         (rst),
    .fb_base     (fb_base),
    .frame_start (frame_start & sel),
    .busy        (busy_b),
    .bus         (ifb)
  );

  assign cur_valid     = sel ? ifb.mem_req_valid : ifa.mem_req_valid;
  assign cur_addr      = sel ? ifb.mem_req_addr  : ifa.mem_req_addr;
  assign cur_empty_n   = sel ? ifb.pixel_empty_n : ifa.pixel_empty_n;
  assign cur_word      = sel ? ifb.pixel_word    : ifa.pixel_word;
  assign cur_underflow = sel ? ifb.underflow     : ifa.underflow;
  assign cur_busy      = sel ? busy_b            : busy_a;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: note handshakes before the edge, then update the in-order memory model
  // so each accepted request is answered in the following cycle unless held.
  task automatic tick();
    logic        hs, rf;
    logic [31:0] hs_addr;
    hs      = cur_valid & mem_req_ready;
    hs_addr = cur_addr;
    rf      = mem_rsp_valid;
    @(posedge pix_clk);
    #1;
    frame_start = 1'b0;
    if (rf) void'(pend.pop_front());
    if (hs) begin
      pend.push_back(hs_addr);
      req_log.push_back(hs_addr);
    end
    mem_rsp_valid = !hold && (pend.size() != 0);
    mem_rsp_data  = mem_rsp_valid ? pat(pend[0]) : 32'h0;
    if (cur_underflow) ufl_seen++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0; ufl_seen = 0;
    rst = 1'b1; frame_start = 1'b0; fb_base = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; pixel_deq = 1'b0; sel = 1'b0; hold = 1'b0;

    tick(); tick();
    check_eq("rst_valid", 32'(cur_valid), 0);
    check_eq("rst_addr", cur_addr, 0);
    check_eq("rst_empty_n", 32'(cur_empty_n), 0);
    check_eq("rst_word", cur_word, 0);
    check_eq("rst_underflow", 32'(cur_underflow), 0);
    check_eq("rst_busy", 32'(cur_busy), 0);
    rst = 1'b0;

    // Full-credit burst from 0x1000 with no consumer.
    fb_base = 32'h1000; frame_start = 1'b1; mem_req_ready = 1'b1;
    tick();
    check_eq("start_busy", 32'(cur_busy), 1);
    check_eq("start_valid", 32'(cur_valid), 1);
    check_eq("start_addr", cur_addr, 32'h1000);
    repeat (40) tick();
    check_eq("burst_count", req_log.size(), 16);
    bad = 0;
    for (int i = 0; i < req_log.size(); i++) begin
      if (req_log[i] !== 32'h1000 + 32'(4 * i)) bad++;
    end
    check_eq("burst_seq", bad, 0);
    check_eq("burst_last", req_log[15], 32'h103C);
    check_eq("burst_valid_low", 32'(cur_valid), 0);
    check_eq("burst_empty_n", 32'(cur_empty_n), 1);

    mem_req_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_eq("drain_word", cur_word, pat(32'h1000 + 32'(4 * i)));
      pixel_deq = 1'b1;
      tick();
      pixel_deq = 1'b0;
    end
    check_eq("drain_empty", 32'(cur_empty_n), 0);
    check_eq("drain_no_ufl", ufl_seen, 0);

    // Stalled request must hold its address.
    check_eq("stall_addr", cur_addr, 32'h1040);
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (!(cur_valid && cur_addr == 32'h1040)) stable = 1'b0;
    end
    check_eq("stall_stable", 32'(stable), 1);
    hold = 1'b1; mem_req_ready = 1'b1;
    repeat (3) tick();
    mem_req_ready = 1'b0;
    check_eq("adv_count", req_log.size(), 19);
    check_eq("adv_0", req_log[16], 32'h1040);
    check_eq("adv_1", req_log[17], 32'h1044);
    check_eq("adv_2", req_log[18], 32'h1048);
    check_eq("outst_3", pend.size(), 3);

    // Restart with three reads in flight.
    fb_base = 32'h8000; frame_start = 1'b1;
    tick();
    check_eq("flush_busy", 32'(cur_busy), 1);
    check_eq("flush_valid", 32'(cur_valid), 0);
    check_eq("flush_empty", 32'(cur_empty_n), 0);
    hold = 1'b0; empty_seen = 1'b0;
    repeat (6) begin
      tick();
      if (cur_empty_n) empty_seen = 1'b1;
    end
    check_eq("flush_drained", pend.size(), 0);
    check_eq("flush_discard", 32'(empty_seen), 0);
    check_eq("refetch_valid", 32'(cur_valid), 1);
    check_eq("refetch_addr", cur_addr, 32'h8000);

    // Dequeue from an empty FIFO.
    ufl_seen = 0;
    check_eq("ufl_idle", 32'(cur_underflow), 0);
    pixel_deq = 1'b1;
    repeat (4) tick();
    check_eq("ufl_count", ufl_seen, 4);
    check_eq("ufl_high", 32'(cur_underflow), 1);
    pixel_deq = 1'b0;
    tick();
    check_eq("ufl_clear", 32'(cur_underflow), 0);
    check_eq("ufl_empty", 32'(cur_empty_n), 0);

    // Reset while two reads are outstanding, with a coincident frame_start.
    hold = 1'b1; mem_req_ready = 1'b1;
    repeat (2) tick();
    mem_req_ready = 1'b0;
    check_eq("pre_rst_outst", pend.size(), 2);
    rst = 1'b1; frame_start = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_valid", 32'(cur_valid), 0);
    check_eq("mid_rst_addr", cur_addr, 0);
    check_eq("mid_rst_busy", 32'(cur_busy), 0);
    check_eq("mid_rst_empty", 32'(cur_empty_n), 0);
    check_eq("mid_rst_word", cur_word, 0);
    hold = 1'b0;
    repeat (4) tick();
    check_eq("late_rsp_done", pend.size(), 0);
    check_eq("late_rsp_empty", 32'(cur_empty_n), 0);
    check_eq("late_rsp_busy", 32'(cur_busy), 0);

    // Small 16x2 frame with a slow consumer, unaligned base.
    sel = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    req_log.delete(); ufl_seen = 0;
    fb_base = 32'h2003; frame_start = 1'b1; mem_req_ready = 1'b1;
    tick();
    check_eq("small_addr", cur_addr, 32'h2000);
    popped = 0; bad = 0;
    for (int i = 0; i < 60; i++) begin
      pixel_deq = (i % 4 == 3) && (popped < 8);
      if (pixel_deq) begin
        if (!cur_empty_n || cur_word !== pat(32'h2000 + 32'(4 * popped))) bad++;
        popped++;
      end
      tick();
    end
    pixel_deq = 1'b0;
    check_eq("small_req_count", req_log.size(), 8);
    check_eq("small_last_addr", req_log[7], 32'h201C);
    check_eq("small_order", bad, 0);
    check_eq("small_popped", popped, 8);
    check_eq("small_no_ufl", ufl_seen, 0);
    check_eq("small_idle", 32'(cur_busy), 0);
    check_eq("small_empty", 32'(cur_empty_n), 0);
    check_eq("small_valid", 32'(cur_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_fetch.md
FB_FETCH -- requirements
Module: fb_fetch

Interface
REQ-001 Parameter H_RES, default 1024, active pixels per line.
REQ-002 Parameter V_RES, default 768, active lines per frame.
REQ-003 Parameter DEPTH, default 16, pixel FIFO depth in 32-bit words (power of 2, at least 4).
REQ-004 Port pix_clk  in  1  clock; all logic on rising edge.
REQ-005 Port rst  in  1  reset: synchronous, active-high.
REQ-006 Port fb_base  in  32  framebuffer byte base address; sampled on frame_start.
REQ-007 Port frame_start  in  1  single-cycle pulse; begins fetching a new frame.
REQ-008 Port mem_req_valid  out  1  read request valid.
REQ-009 Port mem_req_ready  in  1  memory accepts the request this cycle.
REQ-010 Port mem_req_addr  out  32  word-aligned read byte address.
REQ-011 Port mem_rsp_valid  in  1  read data valid; responses return in request order, one per request.
REQ-012 Port mem_rsp_data  in  32  read data; byte 3 is the leftmost pixel.
REQ-013 Port pixel_empty_n  out  1  FIFO holds at least one word.
REQ-014 Port pixel_word  out  32  FIFO head word (show-ahead).
REQ-015 Port pixel_deq  in  1  consumer pops the head word.
REQ-016 Port underflow  out  1  one-cycle pulse on pixel_deq while FIFO is empty.
REQ-017 Port busy  out  1  high in FETCH or FLUSH.

Function
REQ-018 WORDS = H_RES*V_RES/4 words per frame.
REQ-019 FSM states: IDLE, FETCH, FLUSH.
REQ-020 IDLE: no requests; frame_start latches addr=fb_base[31:2]<<2 and req_cnt=0, then moves to FETCH.
REQ-021 FETCH: mem_req_valid=1 while req_cnt<WORDS and (fifo_count+outstanding)<DEPTH.
REQ-022 A request handshake (valid&ready) increments addr by 4, req_cnt by 1 and outstanding by 1.
REQ-023 mem_req_addr and mem_req_valid are registered and held stable until ready.
REQ-024 A response in FETCH enqueues mem_rsp_data and decrements outstanding.
REQ-025 Credit rule: the FIFO can never overflow; a response that arrives while the FIFO is full is a protocol violation.
REQ-026 FETCH returns to IDLE when req_cnt==WORDS and outstanding==0; the FIFO keeps draining.
REQ-027 frame_start in FETCH with outstanding>0 clears the FIFO, latches the new fb_base, and moves to FLUSH.
REQ-028 frame_start in FETCH with outstanding==0 clears the FIFO, latches fb_base, and restarts FETCH with req_cnt=0.
REQ-029 FLUSH: no new requests; each response is discarded and decrements outstanding; at outstanding==0, go to FETCH with req_cnt=0.
REQ-030 frame_start in FLUSH updates the latched fb_base and does not re-clear state.
REQ-031 FIFO supports enqueue and dequeue in the same cycle; fifo_count stays unchanged.
REQ-032 pixel_deq with the FIFO non-empty pops one word; pixel_word updates on the next cycle.
REQ-033 pixel_deq with the FIFO empty has no FIFO effect and asserts underflow on the next cycle.
REQ-034 A FIFO clear coinciding with enqueue or dequeue: the clear wins, and fifo_count=0.
REQ-035 Counters: req_cnt is 20 bits, outstanding and fifo_count are $clog2(DEPTH)+1 bits; addr wraps modulo 2^32.

Reset
REQ-036 rst forces state=IDLE, mem_req_valid=0, mem_req_addr=0, pixel_empty_n=0, pixel_word=0, underflow=0, busy=0, and all counters=0.
REQ-037 rst overrides every other input in the same cycle, including frame_start.
REQ-038 After rst, responses to requests issued before rst are not expected and are ignored in IDLE.

Verification
REQ-039 Scenario: rst, then frame_start with fb_base=0x1000, mem_req_ready=1, 1-cycle response latency, no deq -> addresses 0x1000, 0x1004 ... 0x103C; exactly 16 requests; fifo_count=16; mem_req_valid=0.
REQ-040 Scenario: continuous pixel_deq on every 4th cycle with H_RES=16 and V_RES=2 -> exactly 8 requests; words are delivered in order; state returns to IDLE; no underflow.
REQ-041 Scenario: frame_start mid-frame with 3 responses outstanding and new fb_base=0x8000 -> FLUSH discards 3 responses; pixel_empty_n=0 during FLUSH; the next request address is 0x8000.
REQ-042 Scenario: pixel_deq held high with the FIFO empty -> underflow pulses one cycle after each deq; fifo_count stays 0.
REQ-043 Scenario: mem_req_ready held low for 5 cycles -> mem_req_addr stays stable; after ready, the address advances by 4 per accepted request.
REQ-044 Scenario: rst asserted in FETCH with outstanding=2 -> next cycle all outputs are at reset values; late responses are ignored.
